// File: rtl/vu_pkg.sv
// Shared types, widths and the vol-bus packing helper for the channel visualiser scheduler.
`timescale 1ns/1ps
package vu_pkg;

  localparam int unsigned N_CH    = 7;
  localparam int unsigned CH_W    = 3;
  localparam int unsigned LVL_W   = 3;
  localparam int unsigned LVL_MAX = (1 << LVL_W) - 1;
  localparam int unsigned VOL_W   = (N_CH + 1) * LVL_W;
  localparam int unsigned PLAY_W  = N_CH + 1;
  localparam int unsigned COLOR_W = 3;

  typedef enum logic [1:0] {ACCUM, COMMIT, PUBLISH} state_e;

  // Channel i lives in element i; element 0 is the least significant level.
  typedef logic [N_CH-1:0][LVL_W-1:0] lvl_vec_t;

  // Bottom level slot of the vol bus is unused and always zero.
  function automatic logic [VOL_W-1:0] pack_vol(input lvl_vec_t lv);
    return {lv, LVL_W'(0)};
  endfunction

endpackage

// File: rtl/vu_log_quant.sv
// Combinational log quantiser: msb position of a peak magnitude mapped onto a 0..7 display level.
`timescale 1ns/1ps
module vu_log_quant
  import vu_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic [SAMPLE_W-2:0] mag,
  output logic [LVL_W-1:0]    level_c
);

  localparam int unsigned MAG_W  = SAMPLE_W - 1;
  localparam int unsigned OFFSET = SAMPLE_W - 8;

  int unsigned msb;

  // Levels start one bit above OFFSET and saturate at LVL_MAX.
  always_comb begin
    msb     = 0;
    level_c = '0;
    for (int unsigned i = 0; i < MAG_W; i++) begin
      if (mag[i]) msb = i;
    end
    if (mag != '0 && msb >= OFFSET + 1) begin
      if (msb - OFFSET >= LVL_MAX) level_c = LVL_W'(LVL_MAX);
      else                         level_c = LVL_W'(msb - OFFSET);
    end
  end

endmodule

// File: rtl/vu_frame_scheduler.sv
// Per-frame peak tracker and sequential 7-channel level commit; vol bus and palette index publish atomically.
`timescale 1ns/1ps
module vu_frame_scheduler
  import vu_pkg::*;
#(
  parameter int unsigned SAMPLE_W       = 16,
  parameter int unsigned DECAY_FRAMES   = 4,
  parameter int unsigned PALETTE_FRAMES = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                s_valid,
  input  logic [CH_W-1:0]     s_ch,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic [PLAY_W-1:0]   play,
  output logic [VOL_W-1:0]    vol_o,
  output logic [COLOR_W-1:0]  color_idx,
  output logic                commit_done,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned MAG_W = SAMPLE_W - 1;
  localparam int unsigned DEC_W = $clog2(DECAY_FRAMES + 1);
  localparam int unsigned PAL_W = $clog2(PALETTE_FRAMES + 1);

  state_e               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [MAG_W-1:0]     peak_q [N_CH];
  logic [MAG_W-1:0]     snap_q [N_CH];
  lvl_vec_t             held_q, stage_q;
  logic [DEC_W-1:0]     decay_cnt_q;
  logic [PAL_W-1:0]     pal_cnt_q;
  logic [SAMPLE_W-1:0]  neg_data;
  logic [MAG_W-1:0]     mag;
  logic                 accept, tick_take, commit_en, publish_en, dec_now;
  logic [LVL_W-1:0]     q_lvl, held_cur, stage_val;

  assign accept = s_valid && (s_ch != CH_W'(N_CH));

  // |s_data| with the most negative code saturated to the largest positive magnitude.
  always_comb begin
    neg_data = ~s_data + SAMPLE_W'(1);
    if (!s_data[SAMPLE_W-1])      mag = s_data[MAG_W-1:0];
    else if (neg_data[SAMPLE_W-1]) mag = {MAG_W{1'b1}};
    else                           mag = neg_data[MAG_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    tick_take  = 1'b0;
    commit_en  = 1'b0;
    publish_en = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (frame_tick) begin
          tick_take = 1'b1;
          ch_d      = '0;
          state_d   = COMMIT;
        end
      end
      COMMIT: begin
        commit_en = 1'b1;
        ch_d      = ch_q + CH_W'(1);
        if (ch_q == CH_W'(N_CH - 1)) state_d = PUBLISH;
      end
      PUBLISH: begin
        publish_en = 1'b1;
        state_d    = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Peak tracking runs in every state; a sample in the snapshot cycle seeds the next frame.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (reset) begin
        peak_q[i] <= '0;
        snap_q[i] <= '0;
      end else if (tick_take) begin
        snap_q[i] <= peak_q[i];
        peak_q[i] <= (accept && s_ch == CH_W'(i)) ? mag : '0;
      end else if (accept && s_ch == CH_W'(i) && mag > peak_q[i]) begin
        peak_q[i] <= mag;
      end
    end
  end

  vu_log_quant #(.SAMPLE_W(SAMPLE_W)) u_quant (
    .mag     (snap_q[ch_q]),
    .level_c (q_lvl)
  );

  // Rise immediately to the new level, otherwise fall by one step on decay commits only.
  always_comb begin
    held_cur  = held_q[ch_q];
    dec_now   = (decay_cnt_q == DEC_W'(DECAY_FRAMES - 1));
    stage_val = held_cur;
    if (!play[ch_q + CH_W'(1)])           stage_val = '0;
    else if (q_lvl >= held_cur)           stage_val = q_lvl;
    else if (dec_now && held_cur != '0)   stage_val = held_cur - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vol_o       <= '0;
      color_idx   <= '0;
      commit_done <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      held_q      <= '0;
      stage_q     <= '0;
      decay_cnt_q <= '0;
      pal_cnt_q   <= '0;
    end else begin
      commit_done <= publish_en;
      busy        <= (state_d != ACCUM);
      if (frame_tick && state_q != ACCUM) overrun <= 1'b1;
      if (commit_en) begin
        held_q[ch_q]  <= stage_val;
        stage_q[ch_q] <= stage_val;
      end
      if (publish_en) begin
        vol_o <= pack_vol(stage_q);
        if (decay_cnt_q == DEC_W'(DECAY_FRAMES - 1)) decay_cnt_q <= '0;
        else                                         decay_cnt_q <= decay_cnt_q + DEC_W'(1);
        if (pal_cnt_q == PAL_W'(PALETTE_FRAMES - 1)) begin
          pal_cnt_q <= '0;
          color_idx <= color_idx + COLOR_W'(1);
        end else begin
          pal_cnt_q <= pal_cnt_q + PAL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vu_frame_scheduler.sv
// Directed self-checking bench for vu_frame_scheduler (DECAY_FRAMES=4, PALETTE_FRAMES=2).
`timescale 1ns/1ps
module tb_vu_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        s_valid;
  logic [2:0]  s_ch;
  logic [15:0] s_data;
  logic [7:0]  play;
  logic [23:0] vol_o;
  logic [2:0]  color_idx;
  logic        commit_done;
  logic        overrun;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int pulses;

  vu_frame_scheduler #(
    .SAMPLE_W       (16),
    .DECAY_FRAMES   (4),
    .PALETTE_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .s_valid     (s_valid),
    .s_ch        (s_ch),
    .s_data      (s_data),
    .play        (play),
    .vol_o       (vol_o),
    .color_idx   (color_idx),
    .commit_done (commit_done),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] vol(input int l0, input int l1, input int l2, input int l3,
                                      input int l4, input int l5, input int l6);
    return 32'({l6[2:0], l5[2:0], l4[2:0], l3[2:0], l2[2:0], l1[2:0], l0[2:0], 3'b000});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] ch, input logic [15:0] d);
    @(negedge clk);
    s_valid = 1'b1; s_ch = ch; s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // One tick, then check the 8-cycle latency, the published bus and the one-cycle done pulse.
  task automatic frame(input string tag, input logic [31:0] exp_vol, input logic [31:0] exp_color);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (7) @(negedge clk);
    chk({tag, ".done_early"}, 32'(commit_done), 32'd0);
    chk({tag, ".busy"},       32'(busy),        32'd1);
    @(negedge clk);
    chk({tag, ".done"},       32'(commit_done), 32'd1);
    chk({tag, ".vol"},        32'(vol_o),       exp_vol);
    chk({tag, ".color"},      32'(color_idx),   exp_color);
    chk({tag, ".idle"},       32'(busy),        32'd0);
    @(negedge clk);
    chk({tag, ".done_clr"},   32'(commit_done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; s_valid = 1'b0; s_ch = 3'd0; s_data = 16'h0000; play = 8'hFE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.vol",     32'(vol_o),       32'd0);
    chk("rst.color",   32'(color_idx),   32'd0);
    chk("rst.done",    32'(commit_done), 32'd0);
    chk("rst.overrun", 32'(overrun),     32'd0);
    chk("rst.busy",    32'(busy),        32'd0);

    // Silent frames: commits 1..3
    frame("f1", vol(0,0,0,0,0,0,0), 32'd0);
    frame("f2", vol(0,0,0,0,0,0,0), 32'd1);
    frame("f3", vol(0,0,0,0,0,0,0), 32'd1);

    // Quantiser boundaries, negative saturation, peak max, discard channel: commit 4
    send(3'd0, 16'h8000);
    send(3'd1, 16'h0200);
    send(3'd1, 16'h0050);
    send(3'd2, 16'h01FF);
    send(3'd3, 16'h8000);
    send(3'd4, 16'h1000);
    send(3'd5, 16'hFC00);
    send(3'd6, 16'h0800);
    send(3'd7, 16'h7FFF);
    frame("f4", vol(6,1,0,6,4,2,3), 32'd2);

    // Decay once every 4 commits (commits 8 and 12)
    frame("f5",  vol(6,1,0,6,4,2,3), 32'd2);
    frame("f6",  vol(6,1,0,6,4,2,3), 32'd3);
    frame("f7",  vol(6,1,0,6,4,2,3), 32'd3);
    frame("f8",  vol(5,0,0,5,3,1,2), 32'd4);
    frame("f9",  vol(5,0,0,5,3,1,2), 32'd4);
    frame("f10", vol(5,0,0,5,3,1,2), 32'd5);
    frame("f11", vol(5,0,0,5,3,1,2), 32'd5);
    frame("f12", vol(4,0,0,4,2,0,1), 32'd6);

    // Play gating on channel 0, then re-enable
    play = 8'hFC;
    send(3'd0, 16'h7FFF);
    frame("f13", vol(0,0,0,4,2,0,1), 32'd6);
    play = 8'hFE;
    send(3'd0, 16'h7FFF);
    frame("f14", vol(6,0,0,4,2,0,1), 32'd7);

    // Overrun: second tick 3 cycles into the commit; samples in both tick cycles
    chk("ovr.pre", 32'(overrun), 32'd0);
    @(negedge clk); frame_tick = 1'b1; s_valid = 1'b1; s_ch = 3'd1; s_data = 16'h0400;
    @(negedge clk); frame_tick = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); frame_tick = 1'b1; s_valid = 1'b1; s_ch = 3'd2; s_data = 16'h0200;
    @(negedge clk); frame_tick = 1'b0; s_valid = 1'b0;
    chk("ovr.set",  32'(overrun), 32'd1);
    chk("ovr.busy", 32'(busy),    32'd1);
    pulses = 0;
    for (int i = 5; i <= 20; i++) begin
      @(negedge clk);
      if (commit_done) pulses++;
      if (i == 9) begin
        chk("f15.vol",   32'(vol_o),     vol(6,0,0,4,2,0,1));
        chk("f15.color", 32'(color_idx), 32'd7);
      end
    end
    chk("ovr.pulses", 32'(pulses), 32'd1);
    chk("ovr.sticky", 32'(overrun), 32'd1);
    frame("f16", vol(5,2,1,3,1,0,0), 32'd0);

    // Reset in the middle of a commit
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0; s_valid = 1'b1; s_ch = 3'd0; s_data = 16'h7FFF;
    @(negedge clk); s_valid = 1'b0;
    chk("mid.busy", 32'(busy), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("mid.vol",     32'(vol_o),       32'd0);
    chk("mid.color",   32'(color_idx),   32'd0);
    chk("mid.done",    32'(commit_done), 32'd0);
    chk("mid.overrun", 32'(overrun),     32'd0);
    chk("mid.busy0",   32'(busy),        32'd0);
    reset = 1'b0;
    send(3'd6, 16'h7FFF);
    frame("post", vol(0,0,0,0,0,0,6), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
